// File: rtl/flippy_lane.sv
// One falling-byte lane of the Flippy Bit game: spawns an LFSR target, drops it a row per tick,
// and clears it when a fire press edge arrives with the switches matching the target.
module flippy_lane #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned HEIGHT   = 8,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       enable,
    input  logic [7:0] switches,
    input  logic       fire,
    output logic [7:0] target,
    output logic [3:0] row,
    output logic       active,
    output logic       correct,
    output logic       game_over
);

    localparam int unsigned    CntW    = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
    localparam logic [3:0]     RowLast = 4'(HEIGHT - 1);

    typedef enum logic [1:0] {StSpawn, StFall, StDead} state_e;

    state_e          state_q, state_d;
    logic [7:0]      target_q, target_d;
    logic [3:0]      row_q, row_d;
    logic            correct_q, correct_d;
    logic            game_over_q, game_over_d;
    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic            fire_q;
    logic            press;
    logic            tick;

    assign press = fire & ~fire_q;
    assign tick  = (tick_cnt_q == CntMax);

    always_comb begin
        // Fibonacci taps 8,6,5,4; free-running regardless of enable
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d     = state_q;
        target_d    = target_q;
        row_d       = row_q;
        tick_cnt_d  = tick_cnt_q;
        correct_d   = 1'b0;
        game_over_d = game_over_q;

        if (enable) begin
            unique case (state_q)
                StSpawn: begin
                    target_d   = (lfsr_q == 8'h00) ? 8'h01 : lfsr_q;
                    row_d      = 4'd0;
                    tick_cnt_d = '0;
                    state_d    = StFall;
                end
                StFall: begin
                    // A match beats a coincident final tick
                    if (press && (switches == target_q)) begin
                        correct_d = 1'b1;
                        state_d   = StSpawn;
                    end else begin
                        tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);
                        if (tick) begin
                            if (row_q == RowLast) begin
                                state_d     = StDead;
                                game_over_d = 1'b1;
                            end else begin
                                row_d = row_q + 4'd1;
                            end
                        end
                    end
                end
                StDead: begin
                end
                default: state_d = StSpawn;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q     <= StSpawn;
            target_q    <= 8'h00;
            row_q       <= 4'd0;
            correct_q   <= 1'b0;
            game_over_q <= 1'b0;
            tick_cnt_q  <= '0;
            lfsr_q      <= SEED;
            fire_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            row_q       <= row_d;
            correct_q   <= correct_d;
            game_over_q <= game_over_d;
            tick_cnt_q  <= tick_cnt_d;
            lfsr_q      <= lfsr_d;
            fire_q      <= fire;
        end
    end

    assign target    = target_q;
    assign row       = row_q;
    assign active    = (state_q == StFall);
    assign correct   = correct_q;
    assign game_over = game_over_q;

endmodule
